// File: rtl/conv_pkg.sv
// Shared widths, types and helpers for the 3x3 convolution accumulator.
package conv_pkg;

  localparam int unsigned PIXEL_W      = 8;
  localparam int unsigned COEFF_W      = 8;
  localparam int unsigned NUM_TAPS     = 9;
  localparam int unsigned BOX_W        = PIXEL_W * NUM_TAPS;
  localparam int unsigned PROD_W       = 17;
  localparam int unsigned ROW_W        = 19;
  localparam int unsigned SUM_W        = 21;
  localparam int unsigned IDENTITY_TAP = 4;

  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic signed [ROW_W-1:0]   row_sum_t;
  typedef logic signed [SUM_W-1:0]   sum_t;

  // Identity kernel: centre tap equals the normalisation gain, all others zero.
  function automatic coeff_t identity_coeff(input int unsigned tap, input int unsigned shift);
    return (tap == IDENTITY_TAP) ? coeff_t'(1 << shift) : '0;
  endfunction

  function automatic logic [PIXEL_W-1:0] clamp_pixel(input sum_t val);
    if (val < 0) return '0;
    if (val > 255) return '1;
    return val[PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/conv_accumulator_if.sv
// Window input, coefficient write port and filtered-pixel output stream.
interface conv_accumulator_if;
  import conv_pkg::*;

  logic [BOX_W-1:0]   data_in_box;
  logic               data_in_box_valid;
  logic               coeff_wr_en;
  logic [3:0]         coeff_wr_addr;
  logic [COEFF_W-1:0] coeff_wr_data;
  logic [PIXEL_W-1:0] data_out_pixel;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               data_out_last;
  logic               data_in_ready;
  logic               overflow;

  modport master (
    output data_in_box, data_in_box_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    output data_out_ready,
    input  data_out_pixel, data_out_valid, data_out_last, data_in_ready, overflow
  );

  modport slave (
    input  data_in_box, data_in_box_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    input  data_out_ready,
    output data_out_pixel, data_out_valid, data_out_last, data_in_ready, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push to a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// 3x3 signed-kernel convolution: multiply, row-sum, total/normalise/clamp, then buffer.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = 512,
  parameter int unsigned IW_BIT_NUM  = 9,
  parameter int unsigned NORM_SHIFT  = 3,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic               clk,
  input logic               reset,
  conv_accumulator_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  coeff_t   coeff_q [NUM_TAPS];
  prod_t    prod_d  [NUM_TAPS];
  prod_t    prod_q  [NUM_TAPS];
  row_sum_t row_d   [3];
  row_sum_t row_q   [3];
  logic     s1_valid_q, s2_valid_q;

  sum_t                  total;
  sum_t                  shifted;
  logic [PIXEL_W-1:0]    result;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]       fifo_count;
  logic [IW_BIT_NUM-1:0] row_cnt_q, row_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  at_last;

  // S1 reads coeff_q before this edge's write lands, so a coincident write hits the next window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        coeff_q[k] <= identity_coeff(k, NORM_SHIFT);
      end
    end else if (bus.coeff_wr_en && (bus.coeff_wr_addr < 4'(NUM_TAPS))) begin
      coeff_q[bus.coeff_wr_addr] <= bus.coeff_wr_data;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = prod_t'($signed({1'b0, bus.data_in_box[k*PIXEL_W +: PIXEL_W]}))
                * prod_t'(coeff_q[k]);
    end
    for (int unsigned r = 0; r < 3; r++) begin
      row_d[r] = row_sum_t'(prod_q[3*r]) + row_sum_t'(prod_q[3*r+1])
               + row_sum_t'(prod_q[3*r+2]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.data_in_box_valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.data_in_box_valid) begin
      prod_q <= prod_d;
    end
    if (s1_valid_q) begin
      row_q <= row_d;
    end
  end

  assign total   = sum_t'(row_q[0]) + sum_t'(row_q[1]) + sum_t'(row_q[2]);
  assign shifted = total >>> NORM_SHIFT;
  assign result  = clamp_pixel(shifted);

  assign fifo_pop = bus.data_out_ready && !fifo_empty;

  sync_fifo #(
    .Width (PIXEL_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (s2_valid_q),
    .pop_i   (bus.data_out_ready),
    .data_i  (result),
    .data_o  (bus.data_out_pixel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign at_last = (row_cnt_q == IW_BIT_NUM'(IMAGE_WIDTH - 1));

  always_comb begin
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    if (fifo_pop) begin
      row_cnt_d = at_last ? '0 : row_cnt_q + IW_BIT_NUM'(1);
    end
    if (s2_valid_q && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.data_out_valid = !fifo_empty;
  assign bus.data_out_last  = !fifo_empty && at_last;
  assign bus.data_in_ready  = (fifo_count <= CntW'(FIFO_DEPTH - 4));
  assign bus.overflow       = overflow_q;

endmodule

// File: doc/conv_accumulator.md
CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 512: pixels per output row.
REQ-002 SHALL have parameter IW_BIT_NUM, default 9: width of the row pixel counter.
REQ-003 SHALL have parameter NORM_SHIFT, default 3: arithmetic right shift applied to the kernel sum.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, a power of two and at least 4: output FIFO entries.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port data_in_box, input, 72 bits: 3x3 window; pixel k (k=0..8) = bits [8k+7:8k], unsigned.
REQ-008 SHALL have port data_in_box_valid, input, 1 bit: window valid this cycle; no upstream stall exists.
REQ-009 SHALL have port coeff_wr_en, input, 1 bit: coefficient write strobe.
REQ-010 SHALL have port coeff_wr_addr, input, 4 bits: coefficient index 0..8; values 9..15 are ignored.
REQ-011 SHALL have port coeff_wr_data, input, 8 bits: signed two's-complement coefficient.
REQ-012 SHALL have port data_out_pixel, output, 8 bits: filtered pixel at the FIFO head.
REQ-013 SHALL have port data_out_valid, output, 1 bit: FIFO not empty.
REQ-014 SHALL have port data_out_ready, input, 1 bit: the consumer accepts the pixel; a pop occurs when data_out_valid and data_out_ready are both high.
REQ-015 SHALL have port data_out_last, output, 1 bit: the head pixel is the IMAGE_WIDTH-th pixel of its row.
REQ-016 SHALL have port data_in_ready, output, 1 bit: advisory; high when FIFO fill <= FIFO_DEPTH-4.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag set when a result is dropped.

Function
REQ-018 SHALL hold nine coefficient registers; a write takes effect at the edge where coeff_wr_en is sampled high.
REQ-019 SHALL compute each window with the coefficients held before the edge when a coefficient write and data_in_box_valid coincide.
REQ-020 SHALL, in stage S1 at the edge where data_in_box_valid is high, register 9 products, each a zero-extended pixel times a signed coefficient, as 17-bit signed values.
REQ-021 SHALL, in stage S2, register three row sums (products 0-2, 3-5, 6-8) as 19-bit signed values.
REQ-022 SHALL, in stage S3, form a 21-bit signed total, arithmetic-shift it right by NORM_SHIFT, clamp the result (<0 gives 0, >255 gives 255), and write it to the FIFO.
REQ-023 SHALL carry a valid bit alongside each stage; bubbles propagate and are never written to the FIFO.
REQ-024 SHALL accept one window per cycle sustained; latency from a valid-input cycle to data_out_valid is 3 cycles when the FIFO is empty.
REQ-025 SHALL use a show-ahead FIFO: data_out_pixel is valid whenever data_out_valid is high and holds stable until popped.
REQ-026 SHALL, on a push to a full FIFO without a simultaneous pop, drop the result, leave FIFO contents unchanged and set overflow.
REQ-027 SHALL, on a push to a full FIFO with a simultaneous pop, accept the push with no drop.
REQ-028 SHALL treat a pop while empty as a no-op.
REQ-029 SHALL count pops modulo IMAGE_WIDTH with a row counter; data_out_last = data_out_valid AND count==IMAGE_WIDTH-1; the count wraps to 0 on that pop.
REQ-030 SHALL keep the pipeline running while data_out_ready is low; only the FIFO absorbs backpressure.

Reset
REQ-031 SHALL, while reset is low at a clock edge, clear the stage valids, FIFO pointers, fill count, row counter and overflow.
REQ-032 SHALL load the identity kernel on reset: coeff[4] = 2^NORM_SHIFT (8 at default), all others 0.
REQ-033 SHALL drive these output values out of reset: data_out_valid=0, data_out_last=0, overflow=0, data_in_ready=1, data_out_pixel=0.
REQ-034 SHALL, on reset mid-operation, discard all in-flight and buffered results; the first window after reset is treated as row pixel 0.

Structure
REQ-035 SHALL place PIXEL_W=8, BOX_W=72, PROD_W=17, SUM_W=21 and the identity-kernel constant in shared package conv_pkg.
REQ-036 SHALL implement the FIFO as sub-module sync_fifo, parameterised on width and depth, with push, pop, full, empty and count.
REQ-037 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-038 SHALL check: reset then box with pixel4=0x5A, others 0xFF, valid for 1 cycle -> data_out_pixel=0x5A with data_out_valid high 3 cycles later.
REQ-039 SHALL check: Laplacian kernel (all -1, centre 8), uniform box of 100 -> output 0; centre 200, neighbours 100 -> (800>>3)=100.
REQ-040 SHALL check: all coefficients 8, box all 0xFF -> 255 (clamp high); all coefficients -8, box all 0xFF -> 0 (clamp low).
REQ-041 SHALL check: data_out_ready=0, 12 consecutive valid boxes -> exactly 8 buffered, overflow=1, data_in_ready=0; first 8 results pop in order.
REQ-042 SHALL check: IMAGE_WIDTH=512 streaming with ready=1 -> data_out_last high on pops 511 and 1023 only.
REQ-043 SHALL check: coefficient write coincident with valid -> that box uses the old kernel, the next box uses the new one; reset low mid-stream -> valid drops the cycle after and no stale output appears.
